// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the decode-to-execute pipeline register: width defaults,
// the control-flag bundle and the all-zero bubble value.
package id_ex_pipe_reg_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int RA_W_DEF     = 5;
  localparam int ALUCTL_W_DEF = 3;
  localparam int CNT_W_DEF    = 16;

  typedef struct packed {
    logic regwrite;
    logic alusrc;
    logic memwrite;
    logic resultsrc;
    logic branch;
  } ctrl_flags_t;

  localparam ctrl_flags_t BUBBLE = '0;

  // An invalid decode slot must never carry live controls into execute.
  function automatic ctrl_flags_t gate_ctrl(input ctrl_flags_t c, input logic valid);
    return valid ? c : BUBBLE;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Combinational load-use detector: a live load in E whose destination is read
// by the live instruction in D (x0 never counts).
module id_ex_pipe_reg_load_use_detect #(
  parameter int RA_W = 5
) (
  input  logic            valid_e,
  input  logic            regwrite_e,
  input  logic            resultsrc_e,
  input  logic [RA_W-1:0] rd_e,
  input  logic            valid_d,
  input  logic            uses_rs1_d,
  input  logic [RA_W-1:0] rs1_d,
  input  logic            uses_rs2_d,
  input  logic [RA_W-1:0] rs2_d,
  output logic            lu_hazard
);

  logic load_in_e;
  logic hit1;
  logic hit2;

  assign load_in_e = valid_e & regwrite_e & resultsrc_e;
  assign hit1      = uses_rs1_d & (rs1_d != '0) & (rs1_d == rd_e);
  assign hit2      = uses_rs2_d & (rs2_d != '0) & (rs2_d == rd_e);
  assign lu_hazard = load_in_e & valid_d & (hit1 | hit2);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, branch flush, load-use bubble
// insertion with upstream stall, and a saturating bubble counter.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int RA_W     = RA_W_DEF,
  parameter int ALUCTL_W = ALUCTL_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                o_p_waitrequest,
  input  logic                flush_e,
  input  logic                valid_d,
  input  logic                regwrite_d,
  input  logic                alusrc_d,
  input  logic                memwrite_d,
  input  logic                resultsrc_d,
  input  logic                branch_d,
  input  logic [ALUCTL_W-1:0] alucontrol_d,
  input  logic [XLEN-1:0]     rd1_d,
  input  logic [XLEN-1:0]     rd2_d,
  input  logic [XLEN-1:0]     imm_ext_d,
  input  logic [XLEN-1:0]     pc_d,
  input  logic [XLEN-1:0]     pcplus4_d,
  input  logic [RA_W-1:0]     rs1_d,
  input  logic [RA_W-1:0]     rs2_d,
  input  logic [RA_W-1:0]     rd_d,
  input  logic                uses_rs1_d,
  input  logic                uses_rs2_d,
  output logic                valid_e,
  output logic                regwrite_e,
  output logic                alusrc_e,
  output logic                memwrite_e,
  output logic                resultsrc_e,
  output logic                branch_e,
  output logic [ALUCTL_W-1:0] alucontrol_e,
  output logic [XLEN-1:0]     rd1_e,
  output logic [XLEN-1:0]     rd2_e,
  output logic [XLEN-1:0]     imm_ext_e,
  output logic [XLEN-1:0]     pc_e,
  output logic [XLEN-1:0]     pcplus4_e,
  output logic [RA_W-1:0]     rs1_e,
  output logic [RA_W-1:0]     rs2_e,
  output logic [RA_W-1:0]     rd_e,
  output logic                stall_fd,
  output logic [CNT_W-1:0]    bubble_cnt
);

  ctrl_flags_t         ctrl_d;
  ctrl_flags_t         ctrl_q;
  logic                valid_q;
  logic [ALUCTL_W-1:0] alu_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                lu_hazard;

  assign ctrl_d = '{regwrite:  regwrite_d,
                    alusrc:    alusrc_d,
                    memwrite:  memwrite_d,
                    resultsrc: resultsrc_d,
                    branch:    branch_d};

  id_ex_pipe_reg_load_use_detect #(
    .RA_W (RA_W)
  ) u_lud (
    .valid_e     (valid_q),
    .regwrite_e  (ctrl_q.regwrite),
    .resultsrc_e (ctrl_q.resultsrc),
    .rd_e        (rd_e),
    .valid_d     (valid_d),
    .uses_rs1_d  (uses_rs1_d),
    .rs1_d       (rs1_d),
    .uses_rs2_d  (uses_rs2_d),
    .rs2_d       (rs2_d),
    .lu_hazard   (lu_hazard)
  );

  // stall_fd asks F/D to hold this cycle; it is dropped under a flush because
  // the D instruction is wrong-path and will be discarded anyway.
  assign stall_fd = lu_hazard & ~flush_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= BUBBLE;
      alu_q     <= '0;
      rd1_e     <= '0;
      rd2_e     <= '0;
      imm_ext_e <= '0;
      pc_e      <= '0;
      pcplus4_e <= '0;
      rs1_e     <= '0;
      rs2_e     <= '0;
      rd_e      <= '0;
      cnt_q     <= '0;
    end else if (!o_p_waitrequest) begin
      if (flush_e || lu_hazard) begin
        // Bubble: kill valid and controls, leave datapath fields untouched.
        valid_q <= 1'b0;
        ctrl_q  <= BUBBLE;
        alu_q   <= '0;
        if (!flush_e && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        valid_q   <= valid_d;
        ctrl_q    <= gate_ctrl(ctrl_d, valid_d);
        alu_q     <= valid_d ? alucontrol_d : '0;
        rd1_e     <= rd1_d;
        rd2_e     <= rd2_d;
        imm_ext_e <= imm_ext_d;
        pc_e      <= pc_d;
        pcplus4_e <= pcplus4_d;
        rs1_e     <= rs1_d;
        rs2_e     <= rs2_d;
        rd_e      <= rd_d;
      end
    end
  end

  assign valid_e      = valid_q;
  assign regwrite_e   = ctrl_q.regwrite;
  assign alusrc_e     = ctrl_q.alusrc;
  assign memwrite_e   = ctrl_q.memwrite;
  assign resultsrc_e  = ctrl_q.resultsrc;
  assign branch_e     = ctrl_q.branch;
  assign alucontrol_e = alu_q;
  assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed pipeline scenarios followed by random
// traffic, checked against a behavioural model; a CNT_W=2 copy shares stimulus.
module tb_id_ex_pipe_reg;

  localparam int W = 202;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_p_waitrequest, flush_e, valid_d;
  logic        regwrite_d, alusrc_d, memwrite_d, resultsrc_d, branch_d;
  logic [2:0]  alucontrol_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pcplus4_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        uses_rs1_d, uses_rs2_d;

  logic        valid_e, regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e;
  logic [2:0]  alucontrol_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        stall_fd;
  logic [15:0] bubble_cnt;

  logic        s_valid_e, s_regwrite_e, s_alusrc_e, s_memwrite_e, s_resultsrc_e, s_branch_e;
  logic [2:0]  s_alucontrol_e;
  logic [31:0] s_rd1_e, s_rd2_e, s_imm_ext_e, s_pc_e, s_pcplus4_e;
  logic [4:0]  s_rs1_e, s_rs2_e, s_rd_e;
  logic        s_stall_fd;
  logic [1:0]  s_bubble_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Behavioural model of what execute should be holding.
  logic        m_valid, m_rw, m_as, m_mw, m_rs, m_br;
  logic [2:0]  m_alu;
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pcp4;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  int          m_cnt, m_cnt2;

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .o_p_waitrequest(o_p_waitrequest), .flush_e(flush_e),
    .valid_d(valid_d), .regwrite_d(regwrite_d), .alusrc_d(alusrc_d),
    .memwrite_d(memwrite_d), .resultsrc_d(resultsrc_d), .branch_d(branch_d),
    .alucontrol_d(alucontrol_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d),
    .pc_d(pc_d), .pcplus4_d(pcplus4_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d),
    .valid_e(valid_e), .regwrite_e(regwrite_e), .alusrc_e(alusrc_e),
    .memwrite_e(memwrite_e), .resultsrc_e(resultsrc_e), .branch_e(branch_e),
    .alucontrol_e(alucontrol_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
    .pc_e(pc_e), .pcplus4_e(pcplus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .stall_fd(stall_fd), .bubble_cnt(bubble_cnt)
  );

  id_ex_pipe_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .o_p_waitrequest(o_p_waitrequest), .flush_e(flush_e),
    .valid_d(valid_d), .regwrite_d(regwrite_d), .alusrc_d(alusrc_d),
    .memwrite_d(memwrite_d), .resultsrc_d(resultsrc_d), .branch_d(branch_d),
    .alucontrol_d(alucontrol_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d),
    .pc_d(pc_d), .pcplus4_d(pcplus4_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d),
    .valid_e(s_valid_e), .regwrite_e(s_regwrite_e), .alusrc_e(s_alusrc_e),
    .memwrite_e(s_memwrite_e), .resultsrc_e(s_resultsrc_e), .branch_e(s_branch_e),
    .alucontrol_e(s_alucontrol_e), .rd1_e(s_rd1_e), .rd2_e(s_rd2_e),
    .imm_ext_e(s_imm_ext_e), .pc_e(s_pc_e), .pcplus4_e(s_pcplus4_e),
    .rs1_e(s_rs1_e), .rs2_e(s_rs2_e), .rd_e(s_rd_e),
    .stall_fd(s_stall_fd), .bubble_cnt(s_bubble_cnt)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    return {m_valid, m_rw, m_as, m_mw, m_rs, m_br, m_alu,
            m_rd1, m_rd2, m_imm, m_pc, m_pcp4, m_rs1, m_rs2, m_rd,
            16'(m_cnt), 2'(m_cnt2)};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {valid_e, regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e, alucontrol_e,
            rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e, rs1_e, rs2_e, rd_e,
            bubble_cnt, s_bubble_cnt};
  endfunction

  // Scoreboard: pop the oldest expectation and compare field groups.
  task automatic check_outputs();
    logic [W-1:0] exp, obs;
    exp = exp_q.pop_front();
    obs = dut_vec();
    check("valid_e",    W'(obs[201]),      W'(exp[201]));
    check("controls",   W'(obs[200:193]),  W'(exp[200:193]));
    check("data",       W'(obs[192:33]),   W'(exp[192:33]));
    check("reg_addrs",  W'(obs[32:18]),    W'(exp[32:18]));
    check("bubble_cnt", W'(obs[17:2]),     W'(exp[17:2]));
    check("bubble_sat", W'(obs[1:0]),      W'(exp[1:0]));
  endtask

  task automatic model_reset();
    {m_valid, m_rw, m_as, m_mw, m_rs, m_br} = '0;
    m_alu = '0;
    {m_rd1, m_rd2, m_imm, m_pc, m_pcp4} = '0;
    {m_rs1, m_rs2, m_rd} = '0;
    m_cnt = 0;
    m_cnt2 = 0;
  endtask

  // A live load in E whose destination (not x0) is read by the live D instruction.
  function automatic logic model_hazard();
    logic reads_it;
    reads_it = (uses_rs1_d && rs1_d == m_rd) || (uses_rs2_d && rs2_d == m_rd);
    return m_valid && m_rw && m_rs && valid_d && m_rd != 0 && reads_it;
  endfunction

  task automatic drive(input logic v, input logic rw, input logic as_, input logic mw,
                       input logic rsrc, input logic br, input logic [2:0] alu,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [31:0] imm, input logic [31:0] pc);
    valid_d = v; regwrite_d = rw; alusrc_d = as_; memwrite_d = mw;
    resultsrc_d = rsrc; branch_d = br; alucontrol_d = alu;
    rd_d = rd; rs1_d = rs1; uses_rs1_d = u1; rs2_d = rs2; uses_rs2_d = u2;
    imm_ext_d = imm; pc_d = pc; pcplus4_d = pc + 32'd4;
    rd1_d = $urandom; rd2_d = $urandom;
  endtask

  task automatic cycle(input logic wr, input logic fl);
    logic hz;
    o_p_waitrequest = wr;
    flush_e = fl;
    #1;
    hz = model_hazard();
    check("stall_fd", W'(stall_fd), W'(hz && !fl));
    if (!wr) begin
      if (fl || hz) begin
        {m_valid, m_rw, m_as, m_mw, m_rs, m_br} = '0;
        m_alu = '0;
        if (!fl) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end else begin
        m_valid = valid_d;
        {m_rw, m_as, m_mw, m_rs, m_br} = valid_d ?
            {regwrite_d, alusrc_d, memwrite_d, resultsrc_d, branch_d} : 5'b0;
        m_alu = valid_d ? alucontrol_d : 3'd0;
        m_rd1 = rd1_d; m_rd2 = rd2_d; m_imm = imm_ext_d; m_pc = pc_d; m_pcp4 = pcplus4_d;
        m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
      end
    end
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Reset asserted in the middle of a cycle must clear everything at once.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_vec());
    check_outputs();
    check("stall_in_reset", W'(stall_fd), W'(0));
    #2 rst = 1'b1;
  endtask

  task automatic drive_lw6();
    drive(1, 1, 1, 0, 1, 0, 3'd0, 5'd6, 5'd2, 1, 5'd0, 0, 32'h4, 32'h200);
  endtask

  task automatic drive_add7();
    drive(1, 1, 0, 0, 0, 0, 3'd0, 5'd7, 5'd6, 1, 5'd1, 1, 32'h0, 32'h204);
  endtask

  initial begin
    rst = 1'b0;
    o_p_waitrequest = 1'b0;
    flush_e = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 0, 5'd0, 0, 32'h0, 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_q.push_back(model_vec());
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // addi x5
    drive(1, 1, 1, 0, 0, 0, 3'd0, 5'd5, 5'd0, 1, 5'd0, 0, 32'h10, 32'h100);
    cycle(0, 0);
    check("addi_rd_e", W'(rd_e), W'(5));
    check("addi_pc_e", W'(pc_e), W'(32'h100));

    // lw x6 then dependent add: one bubble, then add enters
    drive_lw6();  cycle(0, 0);
    drive_add7(); cycle(0, 0);
    check("lu_bubble_cnt", W'(bubble_cnt), W'(1));
    cycle(0, 0);
    check("add_entered_rd", W'(rd_e), W'(7));

    // x0 source and unused rs1 never stall
    drive_lw6(); cycle(0, 0);
    drive(1, 1, 0, 0, 0, 0, 3'd1, 5'd7, 5'd0, 1, 5'd0, 1, 32'h0, 32'h208);
    cycle(0, 0);
    drive_lw6(); cycle(0, 0);
    drive(1, 1, 1, 0, 0, 0, 3'd2, 5'd8, 5'd6, 0, 5'd6, 0, 32'h8, 32'h20c);
    cycle(0, 0);
    check("no_stall_cnt", W'(bubble_cnt), W'(1));

    // hazard with flush: flush wins, counter untouched
    drive_lw6();  cycle(0, 0);
    drive_add7(); cycle(0, 1);
    check("flush_cnt", W'(bubble_cnt), W'(1));

    // waitrequest freezes everything for three cycles, then one bubble
    drive_lw6();  cycle(0, 0);
    drive_add7();
    for (int i = 0; i < 3; i++) cycle(1, 0);
    cycle(0, 0);
    check("wait_bubble_cnt", W'(bubble_cnt), W'(2));
    cycle(0, 0);

    // saturating counter on the CNT_W=2 copy: 1,2,3,3,3
    async_reset();
    for (int k = 1; k <= 5; k++) begin
      drive_lw6();  cycle(0, 0);
      drive_add7(); cycle(0, 0);
      check("sat_seq", W'(s_bubble_cnt), W'((k < 3) ? k : 3));
      cycle(0, 0);
    end
    async_reset();
    drive_add7(); cycle(0, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 1),
            5'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom, $urandom);
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      if (n == 200) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
